systolic_skew_feeder: RTL and testbench

Upstream edge stage of the N×N output-stationary PE array. Accepts one k-step beat per cycle: a column of A and a row of B. Re-times each lane into the diagonal skew the array needs. Drives the west/north array edges plus per-PE `clear` and per-PE result-valid strobes. There is no backpressure, because the PEs cannot stall; gaps in `in_valid` become zero bubbles, which add 0 to every accumulator.

---
 rtl/systolic_skew_feeder.sv | 128 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Edge stage for an N x N output-stationary PE array. Takes one k-step beat
//   per cycle (a column of A and a row of B), skews lane i of A and lane j of
//   B by i and j extra cycles, and produces the per-PE accumulator clear and
//   per-PE result-valid strobes aligned to that skew. No backpressure: input
//   gaps become zero bubbles that add nothing to any accumulator.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : beat present this cycle
//   in_last     : beat closes the current tile (qualified by in_valid)
//   in_a, in_b  : N signed lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   a_out       : west edge, lane i feeds PE(i,0)
//   b_out       : north edge, lane j feeds PE(0,j)
//   clear_out   : bit i*N+j clears PE(i,j) accumulator on its first product
//   c_valid     : bit i*N+j marks the cycle PE(i,j) holds a finished result
//   busy        : tile open or anything still in flight
module systolic_skew_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [N*WIDTH-1:0] in_a,
  input  logic [N*WIDTH-1:0] in_b,
  output logic [N*WIDTH-1:0] a_out,
  output logic [N*WIDTH-1:0] b_out,
  output logic [N*N-1:0]     clear_out,
  output logic [N*N-1:0]     c_valid,
  output logic               busy
);

  // Flag lines span lane-0 timing plus the full i+j+1 diagonal.
  localparam int unsigned FLAG_D = 2 * N;

  typedef enum logic {
    IDLE    = 1'b0,
    IN_TILE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   first_tag;
  logic   last_tag;

  // Tile framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tile framing: tag first/last beats; a lone last beat in IDLE is both.
  always_comb begin
    state_d   = state_q;
    first_tag = 1'b0;
    last_tag  = 1'b0;
    if (in_valid) begin
      first_tag = (state_q == IDLE);
      last_tag  = in_last;
      state_d   = in_last ? IDLE : IN_TILE;
    end
  end

  // Flag delay lines; stage 0 is aligned with skew lane 0.
  logic [FLAG_D-1:0] first_line;
  logic [FLAG_D-1:0] last_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_line <= '0;
      last_line  <= '0;
    end else begin
      first_line <= {first_line[FLAG_D-2:0], first_tag};
      last_line  <= {last_line[FLAG_D-2:0], last_tag};
    end
  end

  // Per-lane skew lines: lane i is a shift register of i+1 stages, newest at
  // the LSB end, oldest (the edge output) at the MSB end.
  logic [N-1:0] a_nz;
  logic [N-1:0] b_nz;

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int unsigned LW = (i + 1) * WIDTH;

    logic [WIDTH-1:0] a_din;
    logic [WIDTH-1:0] b_din;
    logic [LW-1:0]    a_sr;
    logic [LW-1:0]    b_sr;

    // Bubbles enter as zeros so they contribute nothing downstream.
    assign a_din = in_valid ? in_a[i*WIDTH +: WIDTH] : '0;
    assign b_din = in_valid ? in_b[i*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_sr <= '0;
        b_sr <= '0;
      end else begin
        a_sr <= (a_sr << WIDTH) | LW'(a_din);
        b_sr <= (b_sr << WIDTH) | LW'(b_din);
      end
    end

    assign a_out[i*WIDTH +: WIDTH] = a_sr[LW-1 -: WIDTH];
    assign b_out[i*WIDTH +: WIDTH] = b_sr[LW-1 -: WIDTH];
    assign a_nz[i] = |a_sr;
    assign b_nz[i] = |b_sr;
  end

  // PE(i,j) sees its operands i+j cycles after lane-0 timing; the result is
  // final one cycle after the last product is accumulated.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign clear_out[i*N+j] = first_line[i+j];
      assign c_valid[i*N+j]   = last_line[i+j+1];
    end
  end

  assign busy = (state_q == IN_TILE) | (|a_nz) | (|b_nz) |
                (|first_line) | (|last_line);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder at N=2, WIDTH=8 with a small
// behavioural output-stationary PE array hung off the edges.
module tb_systolic_skew_feeder;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 2;
  localparam int          NP    = 4;
  localparam int          LOGD  = 16;

  localparam int C1 [NP] = '{19, 22, 43, 50};
  localparam int C2 [NP] = '{5, 6, 7, 8};

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_last;
  logic [N*WIDTH-1:0] in_a;
  logic [N*WIDTH-1:0] in_b;
  logic [N*WIDTH-1:0] a_out;
  logic [N*WIDTH-1:0] b_out;
  logic [NP-1:0]      clear_out;
  logic [NP-1:0]      c_valid;
  logic               busy;

  systolic_skew_feeder #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_out    (a_out),
    .b_out    (b_out),
    .clear_out(clear_out),
    .c_valid  (c_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE array model, PE index p = i*N + j
  logic signed [WIDTH-1:0] pa [NP];
  logic signed [WIDTH-1:0] pb [NP];
  logic signed [WIDTH-1:0] fa [NP];
  logic signed [WIDTH-1:0] fb [NP];
  int acc [NP];

  always_comb begin
    pa[0] = a_out[0 +: WIDTH];
    pa[1] = fa[0];
    pa[2] = a_out[WIDTH +: WIDTH];
    pa[3] = fa[2];
    pb[0] = b_out[0 +: WIDTH];
    pb[1] = b_out[WIDTH +: WIDTH];
    pb[2] = fb[0];
    pb[3] = fb[1];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        fa[p]  <= '0;
        fb[p]  <= '0;
        acc[p] <= 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        fa[p]  <= pa[p];
        fb[p]  <= pb[p];
        acc[p] <= clear_out[p] ? int'(pa[p]) * int'(pb[p])
                               : acc[p] + int'(pa[p]) * int'(pb[p]);
      end
    end
  end

  // Strobe log: cycle (last edge number) and captured accumulator
  int cv_cnt [NP]       = '{default: 0};
  int cl_cnt [NP]       = '{default: 0};
  int cv_t   [NP][LOGD] = '{default: '{default: -1}};
  int cv_v   [NP][LOGD] = '{default: '{default: -1}};
  int cl_t   [NP][LOGD] = '{default: '{default: -1}};

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (c_valid[p] === 1'b1) begin
        if (cv_cnt[p] < LOGD) begin
          cv_t[p][cv_cnt[p]] <= cyc;
          cv_v[p][cv_cnt[p]] <= acc[p];
        end
        cv_cnt[p] <= cv_cnt[p] + 1;
      end
      if (clear_out[p] === 1'b1) begin
        if (cl_cnt[p] < LOGD) cl_t[p][cl_cnt[p]] <= cyc;
        cl_cnt[p] <= cl_cnt[p] + 1;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cv_base [NP];
  int cl_base [NP];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*WIDTH-1:0] pk(input logic [WIDTH-1:0] x0,
                                            input logic [WIDTH-1:0] x1);
    return {x1, x0};
  endfunction

  // Drive one beat at a negedge; e = edge number that samples it
  task automatic beat(input logic v, input logic l, input logic [N*WIDTH-1:0] a,
                      input logic [N*WIDTH-1:0] b, output int e);
    e        = cyc + 1;
    in_valid = v;
    in_last  = l;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
  endtask

  // Invalid cycles carry junk data and a stray in_last that must be ignored
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_a     = pk(8'h5A, 8'hC3);
    in_b     = pk(8'h3C, 8'hA5);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int p = 0; p < NP; p++) begin
      cv_base[p] = cv_cnt[p];
      cl_base[p] = cl_cnt[p];
    end
  endtask

  task automatic chk_counts(input string tag, input int ncl, input int ncv);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s clr_cnt[%0d]", tag, p), cl_cnt[p] - cl_base[p], ncl);
      chk($sformatf("%s cv_cnt[%0d]", tag, p), cv_cnt[p] - cv_base[p], ncv);
    end
  endtask

  // Tile idx since snap: clear after edge f+i+j, c_valid after l+i+j+1
  task automatic chk_pe(input string tag, input int p, input int idx,
                        input int f, input int l, input int cval);
    int d;
    d = p / int'(N) + p % int'(N);
    chk($sformatf("%s clr_t[%0d]", tag, p), cl_t[p][cl_base[p]+idx], f + d);
    chk($sformatf("%s cv_t[%0d]", tag, p), cv_t[p][cv_base[p]+idx], l + d + 1);
    chk($sformatf("%s c[%0d]", tag, p), cv_v[p][cv_base[p]+idx], cval);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a_out"}, a_out, 0);
    chk({tag, " b_out"}, b_out, 0);
    chk({tag, " clear_out"}, clear_out, 0);
    chk({tag, " c_valid"}, c_valid, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, e3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);
    chk("idle busy", busy, 0);

    // 2x2 matmul, K=2 back-to-back beats
    snap();
    beat(1'b1, 1'b0, pk(1, 3), pk(5, 6), e0);
    chk("t1 a0 k0", a_out[7:0], 1);
    chk("t1 a1 k0", a_out[15:8], 0);
    chk("t1 b0 k0", b_out[7:0], 5);
    chk("t1 busy", busy, 1);
    beat(1'b1, 1'b1, pk(2, 4), pk(7, 8), e1);
    chk("t1 a0 k1", a_out[7:0], 2);
    chk("t1 a1 k1", a_out[15:8], 3);
    chk("t1 b1 k1", b_out[15:8], 6);
    idle(1);
    chk("t1 a0 drain", a_out[7:0], 0);
    chk("t1 a1 drain", a_out[15:8], 4);
    chk("t1 b1 drain", b_out[15:8], 8);
    idle(7);
    chk("t1 busy end", busy, 0);
    chk_counts("t1", 1, 1);
    for (int p = 0; p < NP; p++) chk_pe("t1", p, 0, e0, e1, C1[p]);

    // Same matmul with a 2-cycle bubble between k=0 and k=1
    snap();
    beat(1'b1, 1'b0, pk(1, 3), pk(5, 6), e0);
    idle(1);
    chk("t2 a0 bubble", a_out[7:0], 0);
    chk("t2 b0 bubble", b_out[7:0], 0);
    idle(1);
    chk("t2 a bubble", a_out, 0);
    chk("t2 b bubble", b_out, 0);
    beat(1'b1, 1'b1, pk(2, 4), pk(7, 8), e1);
    idle(8);
    chk_counts("t2", 1, 1);
    for (int p = 0; p < NP; p++) chk_pe("t2", p, 0, e0, e1, C1[p]);

    // K=1 tile, all operands -128
    snap();
    beat(1'b1, 1'b1, pk(8'h80, 8'h80), pk(8'h80, 8'h80), e0);
    chk("t3 a0", a_out[7:0], 8'h80);
    idle(8);
    chk("t3 busy end", busy, 0);
    chk_counts("t3", 1, 1);
    for (int p = 0; p < NP; p++) chk_pe("t3", p, 0, e0, e0, 16384);

    // Back-to-back tiles: 2x2 case then identity x B
    snap();
    beat(1'b1, 1'b0, pk(1, 3), pk(5, 6), e0);
    beat(1'b1, 1'b1, pk(2, 4), pk(7, 8), e1);
    beat(1'b1, 1'b0, pk(1, 0), pk(5, 6), e2);
    beat(1'b1, 1'b1, pk(0, 1), pk(7, 8), e3);
    idle(8);
    chk_counts("t4", 2, 2);
    for (int p = 0; p < NP; p++) begin
      chk_pe("t4a", p, 0, e0, e1, C1[p]);
      chk_pe("t4b", p, 1, e2, e3, C2[p]);
    end

    // Reset one cycle after the last beat discards the tile
    snap();
    beat(1'b1, 1'b0, pk(1, 3), pk(5, 6), e0);
    beat(1'b1, 1'b1, pk(2, 4), pk(7, 8), e1);
    chk("t5 busy pre", busy, 1);
    chk("t5 a0 pre", a_out[7:0], 2);
    rst_n = 1'b0;
    #1;
    chk_zero("t5 mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    for (int p = 0; p < NP; p++)
      chk($sformatf("t5 no cv[%0d]", p), cv_cnt[p] - cv_base[p], 0);

    snap();
    beat(1'b1, 1'b0, pk(1, 3), pk(5, 6), e0);
    beat(1'b1, 1'b1, pk(2, 4), pk(7, 8), e1);
    idle(8);
    chk_counts("t6", 1, 1);
    for (int p = 0; p < NP; p++) chk_pe("t6", p, 0, e0, e1, C1[p]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
